// File: rtl/task_stream_pkg.sv
// Shared types and default sizing for the task stream serializer/deserializer pair.
package task_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_STREAMS    = 3;
  localparam int DEFAULT_FIFO_SIZE  = 1024;

  typedef enum logic [1:0] {
    s_IDLE,
    s_FETCH,
    s_SEND
  } ser_state_e;

  // Lane index width; a single lane still needs one bit of index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/task_beat_fifo.sv
// Behavioural synchronous FIFO holding whole beats; registered read data, latency 1.
module task_beat_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] dout_q;
  logic             wr_go;
  logic             rd_go;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign wr_go   = i_wr_en && !o_full;
  assign rd_go   = i_rd_en && !o_empty;
  assign o_dout  = dout_q;

  // NOTE: the storage array is deliberately not reset; pointers and count alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (wr_go) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_go) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_go, rd_go})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/task_serializer.sv
// Buffers framed multi-lane beats and emits them as one byte stream, lane 0 first,
// with first/last framing carried onto the first and last word of each beat.
module task_serializer
  import task_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int INPUT_STREAMS = DEFAULT_STREAMS,
  parameter int FIFO_SIZE     = DEFAULT_FIFO_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data [INPUT_STREAMS],
  input  logic                  i_valid,
  input  logic                  i_first,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic                  o_overflow,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_first,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam int LANES_W = DATA_WIDTH * INPUT_STREAMS;
  localparam int BEAT_W  = LANES_W + 2;
  localparam int IDX_W   = idx_width(INPUT_STREAMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_STREAMS - 1);

  logic [LANES_W-1:0] lanes_in;
  logic               in_frame_q, in_frame_d;
  logic               overflow_q;
  logic               eligible;
  logic               accept;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [BEAT_W-1:0]  fifo_dout;
  ser_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;

  always_comb begin
    lanes_in = '0;
    for (int i = 0; i < INPUT_STREAMS; i++) begin
      lanes_in[i*DATA_WIDTH +: DATA_WIDTH] = i_data[i];
    end
  end

  // Beats outside a frame are dropped silently; only in-frame beats can overflow.
  assign o_ready  = !fifo_full && !i_rst;
  assign eligible = i_valid && (i_first || in_frame_q);
  assign accept   = eligible && o_ready;

  always_comb begin
    in_frame_d = in_frame_q;
    if (accept) in_frame_d = !i_last;
  end

  task_beat_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_SIZE)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr_en (accept),
    .i_din   ({i_first, i_last, lanes_in}),
    .i_rd_en (fifo_rd_en),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      s_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = s_FETCH;
        end
      end
      s_FETCH: begin
        beat_d  = fifo_dout;
        idx_d   = '0;
        state_d = s_SEND;
      end
      s_SEND: begin
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty) begin
              fifo_rd_en = 1'b1;
              state_d    = s_FETCH;
            end else begin
              state_d = s_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = s_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= s_IDLE;
      idx_q      <= '0;
      beat_q     <= '0;
      in_frame_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      in_frame_q <= in_frame_d;
      overflow_q <= eligible && fifo_full;
    end
  end

  // Outputs decode registered state only, so they hold still while downstream stalls.
  assign o_valid    = (state_q == s_SEND);
  assign o_data     = beat_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign o_first    = o_valid && beat_q[BEAT_W-1] && (idx_q == '0);
  assign o_last     = o_valid && beat_q[BEAT_W-2] && (idx_q == LAST_IDX);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_task_serializer.sv
// Self-checking bench for task_serializer: queue-based word model plus directed literal checks.
module tb_task_serializer;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int FS = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_data [N];
  logic          i_valid = 1'b0;
  logic          i_first = 1'b0;
  logic          i_last  = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_ready;
  logic          o_overflow;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_first;
  logic          o_last;

  always #5 i_clk = ~i_clk;

  task_serializer #(
    .DATA_WIDTH    (DW),
    .INPUT_STREAMS (N),
    .FIFO_SIZE     (FS)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_first    (i_first),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_overflow (o_overflow),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_first    (o_first),
    .o_last     (o_last),
    .i_ready    (i_ready)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } word_t;

  word_t         exp_q [$];
  word_t         log_q [$];
  logic [DW-1:0] want_q [$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: frame tracking, beats held by the DUT, position inside the current beat.
  logic  in_frame_m = 1'b0;
  int    pending_m  = 0;
  int    word_pos_m = 0;
  logic  exp_ovf    = 1'b0;
  logic  prev_rst   = 1'b1;
  logic  prev_stall = 1'b0;
  word_t prev_w;
  int    ovf_cnt    = 0;

  always @(negedge i_clk) begin
    logic elig;
    if (prev_rst) begin
      check("rst_valid", o_valid, 0);
      check("rst_overflow", o_overflow, 0);
      check("rst_first", o_first, 0);
      check("rst_last", o_last, 0);
      check("rst_data", o_data, 0);
    end else begin
      check("overflow", o_overflow, exp_ovf);
      if (prev_stall) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, prev_w.d);
        check("stall_first", o_first, prev_w.f);
        check("stall_last", o_last, prev_w.l);
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", o_valid, 0);
        end else begin
          check("data", o_data, exp_q[0].d);
          check("first", o_first, exp_q[0].f);
          check("last", o_last, exp_q[0].l);
        end
      end
    end
    if (o_overflow) ovf_cnt++;
    if (i_rst) begin
      check("ready_in_reset", o_ready, 0);
    end else begin
      check("pending_bound", pending_m <= FS + 1, 1);
      if (pending_m < FS) check("ready_with_room", o_ready, 1);
      if (pending_m == FS + 1) check("ready_when_full", o_ready, 0);
    end

    prev_rst   = i_rst;
    prev_stall = !i_rst && o_valid && !i_ready;
    prev_w.d   = o_data;
    prev_w.f   = o_first;
    prev_w.l   = o_last;

    if (i_rst) begin
      exp_q.delete();
      in_frame_m = 1'b0;
      pending_m  = 0;
      word_pos_m = 0;
      exp_ovf    = 1'b0;
    end else begin
      if (o_valid && i_ready) begin
        word_t w;
        w.d = o_data;
        w.f = o_first;
        w.l = o_last;
        log_q.push_back(w);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        word_pos_m++;
        if (word_pos_m == N) begin
          word_pos_m = 0;
          pending_m--;
        end
      end
      elig    = i_valid && (i_first || in_frame_m);
      exp_ovf = elig && !o_ready;
      if (elig && o_ready) begin
        for (int j = 0; j < N; j++) begin
          word_t w;
          w.d = i_data[j];
          w.f = i_first && (j == 0);
          w.l = i_last && (j == N - 1);
          exp_q.push_back(w);
        end
        pending_m++;
        in_frame_m = !i_last;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input logic f, input logic l);
    i_data[0] = a;
    i_data[1] = b;
    i_data[2] = c;
    i_valid   = 1'b1;
    i_first   = f;
    i_last    = l;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    idle();
    i_ready = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && n < bound) begin
      tick();
      n++;
    end
    check("drain_complete", (exp_q.size() == 0) && !o_valid, 1);
    repeat (2) tick();
  endtask

  // Compares the logged transfers with want_q; first_at/last_at of -1 mean no such flag.
  task automatic check_log(input string tag, input int first_at, input int last_at);
    check({tag, "_count"}, log_q.size(), want_q.size());
    for (int k = 0; k < want_q.size() && k < log_q.size(); k++) begin
      check({tag, "_data"}, log_q[k].d, want_q[k]);
      check({tag, "_first"}, log_q[k].f, k == first_at);
      check({tag, "_last"}, log_q[k].l, k == last_at);
    end
  endtask

  initial begin
    int acc;
    int n;
    for (int j = 0; j < N; j++) i_data[j] = '0;
    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();

    // Two-beat frame, downstream always ready, latency pinned edge by edge.
    log_q.delete();
    i_ready = 1'b1;
    drive(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
    tick();
    check("lat_edge1_valid", o_valid, 0);
    drive(8'h04, 8'h05, 8'h06, 1'b0, 1'b1);
    tick();
    check("lat_edge2_valid", o_valid, 0);
    idle();
    tick();
    check("lat_edge3_valid", o_valid, 1);
    check("lat_edge3_data", o_data, 8'h01);
    drain(50);
    want_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check_log("basic", 0, 5);

    // Same frame under a 1,0,0,1 ready pattern.
    log_q.delete();
    for (int c = 0; c < 40; c++) begin
      if (c == 0) drive(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
      else if (c == 1) drive(8'h04, 8'h05, 8'h06, 1'b0, 1'b1);
      else idle();
      i_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    drain(50);
    check_log("backpressure", 0, 5);

    // Beats with no open frame are discarded without an overflow pulse.
    log_q.delete();
    ovf_cnt = 0;
    drive(8'h5A, 8'h5B, 8'h5C, 1'b0, 1'b0);
    tick();
    drive(8'h6A, 8'h6B, 8'h6C, 1'b0, 1'b1);
    tick();
    idle();
    repeat (10) tick();
    check("unframed_no_words", log_q.size(), 0);
    check("unframed_no_overflow", ovf_cnt, 0);

    // One-beat frame.
    drive(8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1);
    tick();
    drain(50);
    want_q = '{8'hAA, 8'hBB, 8'hCC};
    check_log("one_beat", 0, 2);

    // Overflow: stalled output, seven in-frame beats; one beat moves to the lane register, four fill the FIFO.
    log_q.delete();
    ovf_cnt = 0;
    acc     = 0;
    i_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(8'(3*k+1), 8'(3*k+2), 8'(3*k+3), k == 0, 1'b0);
      if (o_ready) acc++;
      tick();
    end
    idle();
    repeat (3) tick();
    check("ovf_accepted_beats", acc, 5);
    check("ovf_pulses", ovf_cnt, 2);
    check("ovf_ready_low", o_ready, 0);
    drain(100);
    want_q.delete();
    for (int k = 1; k <= 15; k++) want_q.push_back(8'(k));
    check_log("overflow", 0, -1);

    // Reset while the second lane of a beat is on the output.
    log_q.delete();
    i_ready = 1'b1;
    drive(8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
    tick();
    drive(8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
    tick();
    idle();
    n = 0;
    while (!(o_valid && o_data == 8'h22) && n < 20) begin
      tick();
      n++;
    end
    check("midrst_at_idx1", o_data, 8'h22);
    i_ready = 1'b0;
    i_rst   = 1'b1;
    tick();
    check("midrst_valid_low", o_valid, 0);
    check("midrst_ready_low", o_ready, 0);
    i_rst = 1'b0;
    repeat (6) tick();
    check("midrst_words_before", log_q.size(), 1);
    check("midrst_valid_idle", o_valid, 0);
    log_q.delete();
    drive(8'h77, 8'h88, 8'h99, 1'b1, 1'b1);
    tick();
    drain(50);
    want_q = '{8'h77, 8'h88, 8'h99};
    check_log("after_reset", 0, 2);

    // Randomised traffic with varying backpressure and rare resets.
    for (int c = 0; c < 4000; c++) begin
      i_valid = ($urandom % 4) != 0;
      i_first = ($urandom % 5) == 0;
      i_last  = ($urandom % 4) == 0;
      for (int j = 0; j < N; j++) i_data[j] = 8'($urandom);
      if (((c / 500) % 2) == 1) i_ready = ($urandom % 4) == 0;
      else i_ready = ($urandom % 4) != 0;
      i_rst = ($urandom % 700) == 0;
      tick();
    end
    i_rst = 1'b0;
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
